duty_slew: RTL

DUTY_SLEW -- requirements
Module: duty_slew

---
 rtl/duty_slew_pkg.sv | 12 +
 rtl/duty_slew_if.sv | 27 ++
 rtl/period_timer.sv | 22 ++
 rtl/duty_slew.sv | 80 ++++++++
 4 files changed

// File: rtl/duty_slew_pkg.sv
// Shared types and default widths for the duty-cycle slew limiter.
package duty_slew_pkg;

  localparam int unsigned DutyWDefault = 11;
  localparam int unsigned StepWDefault = 8;

  typedef enum logic {
    StIdle,
    StSlew
  } state_e;

endpackage

// File: rtl/duty_slew_if.sv
// Request/duty bundle between a controller (master) and duty_slew (slave).
interface duty_slew_if
  import duty_slew_pkg::*;
#(
  parameter int unsigned DUTY_W = DutyWDefault,
  parameter int unsigned STEP_W = StepWDefault
);

  logic              req_vld;
  logic              req_rdy;
  logic [DUTY_W-1:0] req_duty;
  logic [STEP_W-1:0] req_step;
  logic [DUTY_W-1:0] duty;
  logic              period_start;
  logic              at_target;

  modport master (
    output req_vld, req_duty, req_step,
    input  req_rdy, duty, period_start, at_target
  );

  modport slave (
    input  req_vld, req_duty, req_step,
    output req_rdy, duty, period_start, at_target
  );

endinterface

// File: rtl/period_timer.sv
// Free-running PWM period counter; flags the last count before the wrap.
module period_timer #(
  parameter int unsigned DUTY_W = 11
) (
  input  logic clk,
  input  logic rst,
  output logic period_start
);

  logic [DUTY_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + DUTY_W'(1);
    end
  end

  assign period_start = (cnt_q == '1);

endmodule

// File: rtl/duty_slew.sv
// Slew-limited duty register: takes a target/step request and walks duty toward
// the target by at most one step per PWM period, changing only at period boundaries.
module duty_slew
  import duty_slew_pkg::*;
#(
  parameter int unsigned DUTY_W = DutyWDefault,
  parameter int unsigned STEP_W = StepWDefault
) (
  input logic        clk,
  input logic        rst,
  duty_slew_if.slave bus
);

  logic [DUTY_W-1:0] duty_q, target_q, pend_duty_q, tgt_sel, duty_nxt;
  logic [STEP_W-1:0] step_q, pend_step_q, step_sel;
  logic [DUTY_W:0]   diff, step_ext;
  logic              pend_vld_q, period_start, accept, up;
  state_e            state_q;

  period_timer #(
    .DUTY_W(DUTY_W)
  ) u_period_timer (
    .clk          (clk),
    .rst          (rst),
    .period_start (period_start)
  );

  // A pending request is applied on the boundary that consumes it.
  always_comb begin
    accept   = bus.req_vld && !pend_vld_q;
    tgt_sel  = pend_vld_q ? pend_duty_q : target_q;
    step_sel = pend_vld_q ? pend_step_q : step_q;
    up       = (tgt_sel > duty_q);
    diff     = up ? ({1'b0, tgt_sel} - {1'b0, duty_q}) : ({1'b0, duty_q} - {1'b0, tgt_sel});
    step_ext = (DUTY_W+1)'(step_sel);
    if (step_sel == '0 || diff <= step_ext) begin
      duty_nxt = tgt_sel;
    end else if (up) begin
      duty_nxt = DUTY_W'({1'b0, duty_q} + step_ext);
    end else begin
      duty_nxt = DUTY_W'({1'b0, duty_q} - step_ext);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_q      <= '0;
      target_q    <= '0;
      step_q      <= '0;
      pend_duty_q <= '0;
      pend_step_q <= '0;
      pend_vld_q  <= 1'b0;
      state_q     <= StIdle;
    end else begin
      if (period_start) begin
        duty_q     <= duty_nxt;
        target_q   <= tgt_sel;
        step_q     <= step_sel;
        // A request accepted on the boundary edge waits for the next boundary.
        pend_vld_q <= accept;
        state_q    <= (duty_nxt == tgt_sel && !accept) ? StIdle : StSlew;
      end else if (accept) begin
        pend_vld_q <= 1'b1;
        if (state_q == StIdle && bus.req_duty != duty_q) begin
          state_q <= StSlew;
        end
      end
      if (accept) begin
        pend_duty_q <= bus.req_duty;
        pend_step_q <= bus.req_step;
      end
    end
  end

  assign bus.req_rdy      = !pend_vld_q;
  assign bus.duty         = duty_q;
  assign bus.period_start = period_start;
  assign bus.at_target    = (state_q == StIdle) && !pend_vld_q;

endmodule
